bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter that generates the per-source output enables for the Nbit tri-state buffers driving the shared Simple-RISC data bus.
- Sits directly upstream of the bus buffers: grant[i] connects straight to the en input of source i's buffer.
- Guarantees at most one enable is high at any time, with one dead cycle between owners, so buffers never contend.

Parameters:
- NREQ, 4, number of bus sources (requesters); minimum 2.
- OW, $clog2(NREQ), width of the owner index.
- TIMEOUT, 16, max consecutive grant cycles per owner (used only with the optional feature); minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-source bus request, level-sensitive.
- grant  output  NREQ  one-hot or zero; registered; drives buffer en pins.
- bus_en  output  1  OR of grant; registered.
- owner  output  OW  index of the granted source; 0 when grant==0.
- timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- Reset, asynchronous:
  - grant=0, bus_en=0, owner=0, timeout=0.
  - state=IDLE, last=NREQ-1, so source 0 wins the first arbitration.
- All outputs are registered; no combinational path from req to grant.
- States:
  - IDLE: if req!=0, pick the first set bit searching cyclically from last+1. The next edge sets grant to that one-hot, updates owner and moves to GRANT. If req==0, stay in IDLE.
  - GRANT: grant holds while req[owner]==1. When req[owner]==0 is sampled, the next edge clears grant, sets last=owner and moves to TURN. Requests from other sources do not preempt.
  - TURN: grant=0 for exactly one cycle, the bus turnaround. Arbitration runs in this cycle exactly as in IDLE. The next edge moves to GRANT with a new owner if req!=0, else to IDLE.
- Latency:
  - req rising to grant: 1 cycle from IDLE.
  - Owner's req falling to grant clearing: 1 cycle.
  - Gap between consecutive owners: exactly 1 cycle.
- Boundary conditions:
  - A req pulse that drops before it is sampled gets no grant.
  - A source that re-asserts req during TURN is lowest priority, because last equals that source.
  - A single persistent requester is re-granted after every TURN.
  - Reset mid-GRANT clears grant immediately and asynchronously.
  - The pointer wraps: after last=NREQ-1, the search starts at 0.
  - owner is never X; grant is never multi-hot (assertion).

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- With the macro:
  - A counter counts GRANT cycles for the current owner.
  - When the owner has held the grant TIMEOUT cycles and req[owner] is still 1, the next edge clears grant, sets last=owner, pulses timeout for 1 cycle and enters TURN.
  - The counter resets on every new grant.
- Without the macro: no counter is built, a grant is held indefinitely, and timeout is tied to 0.

Decomposition:
- Shared package bus_pkg:
  - State encoding typedef: IDLE=2'd0, GRANT=2'd1, TURN=2'd2.
  - Default NREQ and TIMEOUT constants.
- One natural sub-module: rr_pick. It is combinational: given req and last, it returns the one-hot winner and its index, and is reused by IDLE and TURN.

Test Plan:
- Hold rst=1 with req=1111 -> grant=0000, bus_en=0, owner=0. Release rst -> grant=0001 one edge later.
- req=0001 for 3 cycles, then 0000 -> grant=0001 for 3 cycles, then 0000; state TURN then IDLE; bus_en follows grant.
- req=1111, each owner drops its req for one cycle after 2 grant cycles, then re-raises -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. The wrap-around is checked.
- last=1 (after source 1 released), req=0110 during TURN -> grant=0100, owner=2.
- Assert rst asynchronously mid-GRANT with owner=3 -> grant=0000 before the next edge; after release, req=1000 -> grant=1000 (last reset to 3 but only one requester).
- With BUS_ARBITER_TIMEOUT_EN and TIMEOUT=16, req=0011 held -> grant=0001 for 16 cycles, timeout pulse, 1 dead cycle, then grant=0010 for 16 cycles. Without the macro, grant=0001 persists and timeout stays 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the Simple-RISC data-bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching cyclically from last+1.
module rr_pick
  import bus_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last,
  output logic [NREQ-1:0] win_c,
  output logic [OW-1:0]   idx_c,
  output logic            any_c
);

  logic [OW-1:0] cand;
  logic          found;

  // Walk the ring starting just after the previous owner; the first hit wins.
  always_comb begin
    win_c = '0;
    idx_c = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = OW'((int'(last) + i) % int'(NREQ));
      if (!found && req[cand]) begin
        found       = 1'b1;
        win_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing tri-state enables for the shared data bus.
// One dead (turnaround) cycle separates consecutive owners.
// Optional forced release after TIMEOUT grant cycles: define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned OW      = $clog2(NREQ),
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            bus_en,
  output logic [OW-1:0]   owner,
  output logic            timeout
);

  localparam bit PARAM_OK = (NREQ >= 2) && (TIMEOUT >= 2);

  state_t          state;
  logic [OW-1:0]   last;
  logic [NREQ-1:0] pick_win;
  logic [OW-1:0]   pick_idx;
  logic            pick_any;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
`else
  assign timeout = 1'b0;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .win_c (pick_win),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Arbitration FSM; grant, bus_en and owner all change together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last   <= OW'(NREQ - 1);
      grant  <= '0;
      bus_en <= 1'b0;
      owner  <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt     <= '0;
      timeout <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        GRANT: begin
          if (!req[owner]) begin
            grant  <= '0;
            bus_en <= 1'b0;
            owner  <= '0;
            last   <= owner;
            state  <= TURN;
          end
`ifdef BUS_ARBITER_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            grant   <= '0;
            bus_en  <= 1'b0;
            owner   <= '0;
            last    <= owner;
            timeout <= 1'b1;
            state   <= TURN;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        default: begin
          // IDLE and TURN arbitrate identically.
          if (pick_any) begin
            grant  <= pick_win;
            bus_en <= 1'b1;
            owner  <= pick_idx;
            state  <= GRANT;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt <= '0;
`endif
          end else begin
            grant  <= '0;
            bus_en <= 1'b0;
            owner  <= '0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  // Buffers must never contend: at most one enable, and bus_en mirrors grant.
  a_onehot : assert property (@(posedge clk) disable iff (rst)
    PARAM_OK && $onehot0(grant) && (bus_en == (|grant)));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NREQ=4, TIMEOUT=16), scoreboard driven.
module tb_bus_arbiter;

  localparam int TIMEOUT = 16;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       bus_en;
  logic [1:0] owner;
  logic       timeout;

  bus_arbiter #(
    .NREQ    (4),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .bus_en  (bus_en),
    .owner   (owner),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_en;
    logic       to;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: 0 idle, 1 grant, 2 turn.
  int m_state, m_last, m_owner, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = 3;
    m_owner = 0;
    m_cnt   = 0;
    sbq.delete();
  endtask

  // Predict the outputs after the next edge given the req sampled there.
  task automatic model_step(input logic [3:0] r);
    exp_t e;
    int   pick;
    int   c;
    e    = '0;
    pick = -1;
    for (int k = 1; k <= 4; k++) begin
      c = (m_last + k) % 4;
      if (pick < 0 && r[c]) pick = c;
    end
    if (m_state == 1) begin
      if (!r[m_owner]) begin
        m_last  = m_owner;
        m_state = 2;
      end else if (TO_EN && m_cnt == TIMEOUT - 1) begin
        m_last  = m_owner;
        m_state = 2;
        e.to    = 1'b1;
      end else begin
        m_cnt++;
        e.grant  = 4'(1 << m_owner);
        e.owner  = 2'(m_owner);
        e.bus_en = 1'b1;
      end
    end else if (pick >= 0) begin
      m_state  = 1;
      m_owner  = pick;
      m_cnt    = 0;
      e.grant  = 4'(1 << pick);
      e.owner  = 2'(pick);
      e.bus_en = 1'b1;
    end else begin
      m_state = 0;
    end
    sbq.push_back(e);
  endtask

  // Drive one cycle of req, then compare DUT outputs against the scoreboard head.
  task automatic cyc(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check("grant",   32'(grant),   32'(e.grant));
      check("owner",   32'(owner),   32'(e.owner));
      check("bus_en",  32'(bus_en),  32'(e.bus_en));
      check("timeout", 32'(timeout), 32'(e.to));
    end
  endtask

  initial begin
    logic [3:0] r;
    rst = 1'b1;
    req = 4'b1111;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant",   32'(grant),   32'h0);
    check("rst_bus_en",  32'(bus_en),  32'h0);
    check("rst_owner",   32'(owner),   32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // Release reset: source 0 wins first.
    rst = 1'b0;
    cyc(4'b1111);
    check("first_win", 32'(grant), 32'h1);
    cyc(4'b0000);
    cyc(4'b0000);

    // Single requester for 3 cycles, then release to TURN and IDLE.
    repeat (3) cyc(4'b0001);
    cyc(4'b0000);
    cyc(4'b0000);

    // All requesting; each owner drops for one cycle after two grant cycles.
    for (int n = 0; n < 14; n++) begin
      r = 4'b1111;
      if (m_state == 1 && m_cnt == 1) r[m_owner] = 1'b0;
      cyc(r);
    end
    cyc(4'b0000);
    cyc(4'b0000);

    // No preemption, then last=1 and req=0110 in TURN picks source 2.
    cyc(4'b0010);
    cyc(4'b0110);
    check("no_preempt", 32'(grant), 32'h2);
    cyc(4'b0100);
    cyc(4'b0110);
    check("turn_pick_grant", 32'(grant), 32'h4);
    check("turn_pick_owner", 32'(owner), 32'h2);
    cyc(4'b0000);
    cyc(4'b0000);

    // Persistent single requester is re-granted after every TURN.
    repeat (3) begin
      cyc(4'b0001);
      cyc(4'b0001);
      cyc(4'b0000);
    end
    cyc(4'b0000);

    // A pulse that drops before being sampled earns nothing.
    req = 4'b0100;
    #2;
    cyc(4'b0000);
    check("pulse_ignored", 32'(grant), 32'h0);

    // Async reset mid-GRANT with owner 3.
    cyc(4'b1000);
    cyc(4'b1000);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_grant",  32'(grant),  32'h0);
    check("async_rst_bus_en", 32'(bus_en), 32'h0);
    check("async_rst_owner",  32'(owner),  32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b1000);
    check("post_rst_grant", 32'(grant), 32'h8);
    cyc(4'b0000);
    cyc(4'b0000);

    // Two sources held: forced hand-off only when the timeout feature is built.
    repeat (40) cyc(4'b0011);
    cyc(4'b0000);
    cyc(4'b0000);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      cyc(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
